// File: rtl/mips_fetch_sequencer.sv
// mips_fetch_sequencer: multi-cycle fetch/exec/mem/wb control FSM for the MIPS core,
// with branch delay-slot redirect sequencing and halt-on-target detection.
module mips_fetch_sequencer #(
    parameter logic [31:0] HALT_ADDR        = 32'h0000_0000,
    parameter int unsigned RESET_STATE_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_waitrequest,
    input  logic        instr_needs_mem,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_read,
    output logic        data_access,
    output logic        reg_write_en,
    output logic        CntEn,
    output logic [1:0]  PCControl,
    output logic [31:0] redirect_addr,
    output logic        active,
    output logic        slot_branch_err,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [2:0] HOLD_LAST = 3'(RESET_STATE_HOLD - 1);

    state_t      state_q, state_d;
    logic [2:0]  hold_q, hold_d;
    logic        pending_q, pending_d;
    logic        armed_q, armed_d;
    logic [31:0] redirect_q, redirect_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= 3'd0;
            pending_q  <= 1'b0;
            armed_q    <= 1'b0;
            redirect_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            armed_q    <= armed_d;
            redirect_q <= redirect_d;
            err_q      <= err_d;
        end
    end

    // armed_q marks a branch in flight; it becomes pending once that branch retires,
    // so the redirect lands on the delay-slot instruction's writeback.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        armed_d    = armed_q;
        redirect_d = redirect_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (hold_q == HOLD_LAST) state_d = FETCH;
                else hold_d = hold_q + 3'd1;
            end
            FETCH: if (!mem_waitrequest) state_d = EXEC;
            EXEC: begin
                state_d = instr_needs_mem ? MEM : WB;
                if (branch_taken && pending_q) err_d = 1'b1;
                else if (branch_taken) begin
                    redirect_d = branch_target;
                    armed_d    = 1'b1;
                end
            end
            MEM: if (!mem_waitrequest) state_d = WB;
            WB: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = (redirect_q == HALT_ADDR) ? HALT : FETCH;
                end else begin
                    pending_d = armed_q;
                    armed_d   = 1'b0;
                    state_d   = FETCH;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        fetch_read      = state_q == FETCH;
        data_access     = state_q == MEM;
        reg_write_en    = state_q == WB;
        CntEn           = state_q == WB;
        PCControl       = (state_q == WB && pending_q) ? 2'b10 : 2'b11;
        redirect_addr   = redirect_q;
        active          = state_q inside {FETCH, EXEC, MEM, WB};
        slot_branch_err = err_q;
        state           = state_q;
    end
endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// tb_mips_fetch_sequencer: randomized instruction stream checked cycle by cycle against
// an instruction-level model of retirement, delay-slot redirect and halt.
module tb_mips_fetch_sequencer;
    localparam int          HOLD = 3;
    localparam logic [31:0] HALT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_waitrequest, instr_needs_mem, branch_taken;
    logic [31:0] branch_target;
    logic        fetch_read, data_access, reg_write_en, CntEn, active, slot_branch_err;
    logic [1:0]  PCControl;
    logic [31:0] redirect_addr;
    logic [2:0]  state;

    mips_fetch_sequencer #(.HALT_ADDR(HALT), .RESET_STATE_HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .mem_waitrequest(mem_waitrequest),
        .instr_needs_mem(instr_needs_mem), .branch_taken(branch_taken),
        .branch_target(branch_target), .fetch_read(fetch_read), .data_access(data_access),
        .reg_write_en(reg_write_en), .CntEn(CntEn), .PCControl(PCControl),
        .redirect_addr(redirect_addr), .active(active), .slot_branch_err(slot_branch_err),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit          m_slot;
    logic [31:0] m_tgt;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string ph, input logic [2:0] st, input bit fr, input bit da,
                             input bit wb, input bit act, input logic [1:0] pc);
        chk({ph, " state"}, state, st);
        chk({ph, " fetch_read"}, fetch_read, fr);
        chk({ph, " data_access"}, data_access, da);
        chk({ph, " reg_write_en"}, reg_write_en, wb);
        chk({ph, " CntEn"}, CntEn, wb);
        chk({ph, " active"}, active, act);
        chk({ph, " PCControl"}, PCControl, pc);
        chk({ph, " redirect_addr"}, redirect_addr, m_tgt);
        chk({ph, " slot_branch_err"}, slot_branch_err, m_err);
    endtask

    task automatic noise();
        branch_taken    = 1'($urandom);
        instr_needs_mem = 1'($urandom);
        branch_target   = $urandom;
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        m_slot = 0;
        m_tgt  = 32'h0;
        m_err  = 0;
        #1 chk_cycle("reset", 3'd0, 0, 0, 0, 0, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (state == 3'd0 && n < 20) begin
            chk_cycle("idle", 3'd0, 0, 0, 0, 0, 2'b11);
            @(negedge clk);
            n++;
        end
        chk("idle_hold_cycles", n, HOLD);
    endtask

    task automatic run_instr(input int fs, input bit nm, input int ms, input bit tk,
                             input logic [31:0] tg, output bit halted);
        bit slot_now, next_slot;
        slot_now  = m_slot;
        next_slot = tk && !m_slot;
        for (int i = 0; i <= fs; i++) begin
            noise();
            mem_waitrequest = (i < fs);
            chk_cycle("fetch", 3'd1, 1, 0, 0, 1, 2'b11);
            @(negedge clk);
        end
        branch_taken    = tk;
        branch_target   = tg;
        instr_needs_mem = nm;
        mem_waitrequest = 1'($urandom);
        chk_cycle("exec", 3'd2, 0, 0, 0, 1, 2'b11);
        @(negedge clk);
        if (tk) begin
            if (m_slot) m_err = 1;
            else m_tgt = tg;
        end
        if (nm) begin
            for (int i = 0; i <= ms; i++) begin
                noise();
                mem_waitrequest = (i < ms);
                chk_cycle("mem", 3'd3, 0, 1, 0, 1, 2'b11);
                @(negedge clk);
            end
        end
        noise();
        mem_waitrequest = 1'($urandom);
        chk_cycle("wb", 3'd4, 0, 0, 1, 1, slot_now ? 2'b10 : 2'b11);
        @(negedge clk);
        halted = slot_now && (m_tgt == HALT);
        m_slot = next_slot;
    endtask

    initial begin
        bit h;
        rst_n = 1'b0;
        mem_waitrequest = 1'b0;
        instr_needs_mem = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 0, 32'h0, h);
        run_instr(2, 1, 3, 0, 32'h0, h);
        run_instr(0, 0, 0, 1, 32'hBFC0_0040, h);
        run_instr(0, 0, 0, 0, 32'h0, h);
        run_instr(0, 0, 0, 1, 32'h0000_1000, h);
        run_instr(1, 1, 1, 1, 32'h0000_1234, h);
        run_instr(0, 0, 0, 0, 32'h0, h);
        for (int i = 0; i < 40; i++)
            run_instr($urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3) == 0, $urandom | 32'h4, h);
        // arm a branch, then reset while the delay-slot instruction sits in MEM
        do_reset();
        run_instr(0, 0, 0, 1, 32'h0000_2000, h);
        mem_waitrequest = 1'b0;
        chk_cycle("pre_rst_fetch", 3'd1, 1, 0, 0, 1, 2'b11);
        @(negedge clk);
        instr_needs_mem = 1'b1;
        branch_taken = 1'b0;
        chk_cycle("pre_rst_exec", 3'd2, 0, 0, 0, 1, 2'b11);
        @(negedge clk);
        mem_waitrequest = 1'b1;
        chk_cycle("pre_rst_mem", 3'd3, 0, 1, 0, 1, 2'b11);
        do_reset();
        run_instr(0, 0, 0, 0, 32'h0, h);
        run_instr(1, 1, 2, 0, 32'h0, h);
        run_instr(0, 0, 0, 1, HALT, h);
        run_instr(0, 1, 1, 0, 32'h0, h);
        for (int i = 0; i < 20; i++) begin
            noise();
            mem_waitrequest = 1'($urandom);
            chk_cycle("halt", 3'd5, 0, 0, 0, 0, 2'b11);
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
